// File: rtl/pattern_step_seq_if.sv
// Bundle between the pattern-step sequencer and its ROM / 7-seg consumers.
// The sequencer owns every signal except the pause level.
interface pattern_step_seq_if;
    logic       pause;
    logic [3:0] ptn_cnt;
    logic [2:0] lap_cnt;
    logic       dir;
    logic       step;
    logic       turn;

    modport master (input pause, output ptn_cnt, lap_cnt, dir, step, turn);
    modport slave  (output pause, input ptn_cnt, lap_cnt, dir, step, turn);
endinterface

// File: rtl/pattern_step_seq.sv
// Running-pattern sequencer: free-running tick divider plus an up/down position
// counter that counts laps and reverses direction after N_LAP laps.
module pattern_step_seq #(
    parameter int DIV_FAST = 23,
    parameter int DIV_SLOW = 24,
    parameter int N_PTN    = 10,
    parameter int N_LAP    = 5
) (
    input  logic               clk,
    input  logic               rst,
    pattern_step_seq_if.master bus
);
    typedef enum logic {CW = 1'b0, CCW = 1'b1} dir_e;

    localparam logic [3:0] PTN_MAX = 4'(N_PTN - 1);
    localparam logic [2:0] LAP_MAX = 3'(N_LAP - 1);

    dir_e                dir_q, dir_d;
    logic [DIV_SLOW-1:0] div_cnt;
    logic [3:0]          ptn_q, ptn_d;
    logic [2:0]          lap_q, lap_d;
    logic                step_q, turn_q, turn_d;
    logic                slow_tick, fast_tick, tick;

    // The divider keeps running across a reversal, so the first fast tick
    // lands wherever the low bits happen to be.
    assign slow_tick = &div_cnt;
    assign fast_tick = &div_cnt[DIV_FAST-1:0];
    assign tick      = !bus.pause && ((dir_q == CCW) ? fast_tick : slow_tick);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            dir_q   <= CW;
            ptn_q   <= '0;
            lap_q   <= '0;
            step_q  <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            if (!bus.pause) div_cnt <= div_cnt + 1'b1;
            dir_q  <= dir_d;
            ptn_q  <= ptn_d;
            lap_q  <= lap_d;
            step_q <= tick;
            turn_q <= turn_d;
        end
    end

    always_comb begin
        dir_d  = dir_q;
        ptn_d  = ptn_q;
        lap_d  = lap_q;
        turn_d = 1'b0;
        if (tick) begin
            case (dir_q)
                CW: begin
                    if (ptn_q != PTN_MAX) begin
                        ptn_d = ptn_q + 4'd1;
                    end else if (lap_q != LAP_MAX) begin
                        ptn_d = '0;
                        lap_d = lap_q + 3'd1;
                    end else begin
                        // Position holds at the end of the lap on a reversal.
                        lap_d  = '0;
                        dir_d  = CCW;
                        turn_d = 1'b1;
                    end
                end
                CCW: begin
                    if (ptn_q != 4'd0) begin
                        ptn_d = ptn_q - 4'd1;
                    end else if (lap_q != LAP_MAX) begin
                        ptn_d = PTN_MAX;
                        lap_d = lap_q + 3'd1;
                    end else begin
                        lap_d  = '0;
                        dir_d  = CW;
                        turn_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ptn_cnt = ptn_q;
    assign bus.lap_cnt = lap_q;
    assign bus.dir     = dir_q;
    assign bus.step    = step_q;
    assign bus.turn    = turn_q;
endmodule

// File: tb/tb_pattern_step_seq.sv
// Bench for pattern_step_seq: directed phases plus random pause, checked every
// cycle against a tick-count model of the lap/position sequence.
module tb_pattern_step_seq;
    localparam int DF = 2, DS = 3, NP = 10, NL = 3;
    localparam int PHASE = NP * NL;

    logic clk, rst;
    pattern_step_seq_if sif ();

    pattern_step_seq #(.DIV_FAST(DF), .DIV_SLOW(DS), .N_PTN(NP), .N_LAP(NL)) dut (
        .clk(clk), .rst(rst), .bus(sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0, n_fail = 0;
    // Model: unpaused cycle count, ticks taken in the current direction, direction.
    int m_div, m_k, m_dir;
    logic m_step, m_turn;

    function automatic int exp_ptn();
        return m_dir ? (NP - 1 - (m_k % NP)) : (m_k % NP);
    endfunction
    function automatic int exp_lap();
        return m_k / NP;
    endfunction

    task automatic model_reset();
        m_div = 0; m_k = 0; m_dir = 0; m_step = 1'b0; m_turn = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ptn"},  int'(sif.ptn_cnt), exp_ptn());
        chk({tag, ".lap"},  int'(sif.lap_cnt), exp_lap());
        chk({tag, ".dir"},  int'(sif.dir),     m_dir);
        chk({tag, ".step"}, int'(sif.step),    int'(m_step));
        chk({tag, ".turn"}, int'(sif.turn),    int'(m_turn));
    endtask

    // One clock with the given pause level; model advances from pre-edge state.
    task automatic cyc(input logic p, input string tag);
        int per;
        logic tk;
        sif.pause = p;
        @(posedge clk);
        per = m_dir ? (1 << DF) : (1 << DS);
        tk  = !p && ((m_div % per) == per - 1);
        if (!p) m_div = (m_div + 1) % (1 << DS);
        m_step = tk;
        m_turn = 1'b0;
        if (tk) begin
            m_k++;
            if (m_k == PHASE) begin
                m_k = 0; m_dir = 1 - m_dir; m_turn = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int budget;
        int ptn_hold;
        rst = 1'b0;
        sif.pause = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst = 1'b1;

        // First slow tick on the 8th edge after release.
        repeat (7) cyc(1'b0, "boot");
        chk("boot7.ptn", int'(sif.ptn_cnt), 0);
        cyc(1'b0, "boot8");
        chk("boot8.ptn", int'(sif.ptn_cnt), 1);
        chk("boot8.step", int'(sif.step), 1);
        cyc(1'b0, "boot9");
        chk("boot9.step", int'(sif.step), 0);

        // Run through CW laps, the reversal, and the CCW phase back to CW.
        budget = 0;
        while (!(m_dir == 1 && m_k == 1) && budget < 400) begin
            cyc(1'b0, "cw");
            budget++;
        end
        chk("cw_to_ccw.reached", (m_dir == 1 && m_k == 1) ? 1 : 0, 1);
        chk("ccw_first.ptn", int'(sif.ptn_cnt), NP - 2);
        budget = 0;
        while (!(m_dir == 0 && m_k == 0 && m_turn) && budget < 200) begin
            cyc(1'b0, "ccw");
            budget++;
        end
        chk("ccw_to_cw.reached", (m_dir == 0 && m_turn) ? 1 : 0, 1);
        chk("ccw_to_cw.ptn", int'(sif.ptn_cnt), 0);
        chk("ccw_to_cw.turn", int'(sif.turn), 1);

        // Pause mid-lap for 20 clocks, then resume from the held divider.
        repeat (19) cyc(1'b0, "pre_pause");
        ptn_hold = int'(sif.ptn_cnt);
        repeat (20) cyc(1'b1, "pause");
        chk("pause.ptn_held", int'(sif.ptn_cnt), ptn_hold);
        repeat (12) cyc(1'b0, "resume");

        // Random pause pattern across several phases.
        repeat (900) cyc(($urandom_range(0, 3) == 0), "rand");

        // Async reset mid-run while CCW on the last lap.
        budget = 0;
        while (!(m_dir == 1 && exp_lap() == 2) && budget < 600) begin
            cyc(1'b0, "seek");
            budget++;
        end
        chk("seek.reached", (m_dir == 1 && exp_lap() == 2) ? 1 : 0, 1);
        #3 rst = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        repeat (3) begin
            @(posedge clk);
            #1 check_all("rst_hold");
        end
        @(negedge clk) rst = 1'b1;
        repeat (7) cyc(1'b0, "reboot");
        cyc(1'b0, "reboot8");
        chk("reboot8.step", int'(sif.step), 1);
        repeat (300) cyc(($urandom_range(0, 4) == 0), "rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
